// File: rtl/timer_adv.sv
// rtl/timer_adv.sv - Countdown/stopwatch timer with field editing, alarm and optional auto-reload
module timer_adv #(
    parameter int TICK_DIV   = 1000000,
    parameter int HOUR_MAX   = 99,
    parameter int ALARM_SECS = 10,
    parameter int RELOAD     = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        enter,
    input  logic        esc,
    input  logic        mode,
    input  logic        dir,
    output logic [23:0] bcd,
    output logic [2:0]  field_sel,
    output logic        norm,
    output logic        alarm,
    output logic        running
);
    localparam int HW = $clog2(HOUR_MAX + 1);
    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(ALARM_SECS + 1);
    localparam logic [HW-1:0] H_MAX  = HW'(HOUR_MAX);
    localparam logic [HW-1:0] H_ONE  = HW'(1);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [AW-1:0] A_LAST = AW'(ALARM_SECS - 1);
    localparam logic [AW-1:0] A_ONE  = AW'(1);
    localparam logic [2:0] F_SEC = 3'b001, F_MIN = 3'b010, F_HOUR = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_SET, S_RUN, S_ALARM} state_t;

    state_t          state_q, state_d;
    logic [2:0]      field_q, field_d;
    logic [HW-1:0]   hour_q, hour_d, pre_h_q, pre_h_d;
    logic [5:0]      min_q, min_d, sec_q, sec_d, pre_m_q, pre_m_d, pre_s_q, pre_s_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [AW-1:0]   acnt_q, acnt_d;
    logic            dir_q, dir_d;
    logic [5:0]      prev_q, prev_d, arm_q, arm_d;
    logic [23:0]     bcd_q, bcd_d;
    logic [2:0]      field_sel_q, field_sel_d;
    logic            norm_q, norm_d, alarm_q, alarm_d, running_q, running_d;
    logic [5:0]      btn, edge_v;
    logic            tick, time_zero, pre_zero;
    logic [6:0]      h7;

    always_comb begin
        btn       = {esc, enter, right, left, down, up};
        // arm_q stays low until a button is seen released, so a press held through reset is ignored
        edge_v    = btn & ~prev_q & arm_q;
        prev_d    = btn;
        arm_d     = arm_q | ~btn;
        state_d   = state_q;
        field_d   = field_q;
        hour_d    = hour_q;
        min_d     = min_q;
        sec_d     = sec_q;
        pre_h_d   = pre_h_q;
        pre_m_d   = pre_m_q;
        pre_s_d   = pre_s_q;
        presc_d   = '0;
        acnt_d    = '0;
        dir_d     = dir_q;
        tick      = (presc_q == P_LAST);
        time_zero = (hour_q == '0) && (min_q == '0) && (sec_q == '0);
        pre_zero  = (pre_h_q == '0) && (pre_m_q == '0) && (pre_s_q == '0);

        if (edge_v[5] || !mode) begin
            state_d = S_IDLE;
            field_d = F_SEC;
            hour_d  = '0;
            min_d   = '0;
            sec_d   = '0;
            pre_h_d = '0;
            pre_m_d = '0;
            pre_s_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (edge_v[4]) begin
                        state_d = S_SET;
                        field_d = F_SEC;
                    end else if (edge_v[3] && (dir || !time_zero)) begin
                        state_d = S_RUN;
                        dir_d   = dir;
                    end
                end
                S_SET: begin
                    if (edge_v[4]) begin
                        state_d = S_IDLE;
                        pre_h_d = hour_q;
                        pre_m_d = min_q;
                        pre_s_d = sec_q;
                    end else begin
                        if (edge_v[2])      field_d = {field_q[1:0], field_q[2]};
                        else if (edge_v[3]) field_d = {field_q[0], field_q[2:1]};
                        if (edge_v[0] || edge_v[1]) begin
                            case (field_q)
                                F_HOUR:  hour_d = edge_v[0] ? ((hour_q == H_MAX) ? '0 : hour_q + H_ONE)
                                                            : ((hour_q == '0) ? H_MAX : hour_q - H_ONE);
                                F_MIN:   min_d  = edge_v[0] ? ((min_q == 6'd59) ? 6'd0 : min_q + 6'd1)
                                                            : ((min_q == 6'd0) ? 6'd59 : min_q - 6'd1);
                                default: sec_d  = edge_v[0] ? ((sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1)
                                                            : ((sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1);
                            endcase
                        end
                    end
                end
                S_RUN: begin
                    if (edge_v[4]) begin
                        state_d = S_IDLE;
                    end else begin
                        presc_d = tick ? '0 : presc_q + P_ONE;
                        if (tick && !dir_q) begin
                            if (time_zero) begin
                                state_d = S_ALARM;
                            end else begin
                                if (sec_q != 6'd0) begin
                                    sec_d = sec_q - 6'd1;
                                end else begin
                                    sec_d = 6'd59;
                                    if (min_q != 6'd0) begin
                                        min_d = min_q - 6'd1;
                                    end else begin
                                        min_d  = 6'd59;
                                        hour_d = hour_q - H_ONE;
                                    end
                                end
                                if (hour_q == '0 && min_q == '0 && sec_q == 6'd1) state_d = S_ALARM;
                            end
                        end else if (tick) begin
                            // stopwatch stops on reaching the top value instead of wrapping
                            if (hour_q == H_MAX && min_q == 6'd59 && sec_q >= 6'd58) state_d = S_IDLE;
                            if (sec_q < 6'd59) begin
                                sec_d = sec_q + 6'd1;
                            end else if (hour_q != H_MAX || min_q != 6'd59) begin
                                sec_d = 6'd0;
                                if (min_q < 6'd59) begin
                                    min_d = min_q + 6'd1;
                                end else begin
                                    min_d  = 6'd0;
                                    hour_d = hour_q + H_ONE;
                                end
                            end
                        end
                    end
                end
                S_ALARM: begin
                    presc_d = tick ? '0 : presc_q + P_ONE;
                    acnt_d  = tick ? acnt_q + A_ONE : acnt_q;
                    if ((tick && acnt_q == A_LAST) || (|edge_v[4:0])) begin
                        presc_d = '0;
                        acnt_d  = '0;
                        if (RELOAD != 0 && !pre_zero) begin
                            state_d = S_RUN;
                            hour_d  = pre_h_q;
                            min_d   = pre_m_q;
                            sec_d   = pre_s_q;
                        end else begin
                            state_d = S_IDLE;
                            hour_d  = '0;
                            min_d   = '0;
                            sec_d   = '0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        running_d   = (state_d == S_RUN);
        alarm_d     = (state_d == S_ALARM);
        norm_d      = (state_d != S_SET);
        field_sel_d = (state_d == S_SET) ? field_d : 3'b000;
        h7          = 7'(hour_q);
        bcd_d       = {4'(h7 / 7'd10), 4'(h7 % 7'd10), 4'(min_q / 6'd10), 4'(min_q % 6'd10),
                       4'(sec_q / 6'd10), 4'(sec_q % 6'd10)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            field_q     <= F_SEC;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            pre_h_q     <= '0;
            pre_m_q     <= '0;
            pre_s_q     <= '0;
            presc_q     <= '0;
            acnt_q      <= '0;
            dir_q       <= 1'b0;
            prev_q      <= '0;
            arm_q       <= '0;
            bcd_q       <= '0;
            field_sel_q <= '0;
            norm_q      <= 1'b1;
            alarm_q     <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            field_q     <= field_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            pre_h_q     <= pre_h_d;
            pre_m_q     <= pre_m_d;
            pre_s_q     <= pre_s_d;
            presc_q     <= presc_d;
            acnt_q      <= acnt_d;
            dir_q       <= dir_d;
            prev_q      <= prev_d;
            arm_q       <= arm_d;
            bcd_q       <= bcd_d;
            field_sel_q <= field_sel_d;
            norm_q      <= norm_d;
            alarm_q     <= alarm_d;
            running_q   <= running_d;
        end
    end

    assign bcd       = bcd_q;
    assign field_sel = field_sel_q;
    assign norm      = norm_q;
    assign alarm     = alarm_q;
    assign running   = running_q;
endmodule

// File: doc/timer_adv.md
TIMER_ADV -- requirements
Module: timer_adv

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, clk cycles per one-second tick (>=2).
REQ-002 SHALL have parameter HOUR_MAX, default 99, max hour value (1..99).
REQ-003 SHALL have parameter ALARM_SECS, default 10, alarm duration in ticks (>=1).
REQ-004 SHALL have parameter RELOAD, default 0; 1 = auto-reload preset and restart after alarm.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports up, down, left, right, enter, esc  input  1 each  raw button levels, synchronous to clk.
REQ-008 SHALL have port mode  input  1  block enable; 0 forces IDLE with time cleared.
REQ-009 SHALL have port dir  input  1  0 = count down, 1 = count up (stopwatch); sampled only on IDLE->RUN.
REQ-010 SHALL have port bcd  output  24  BCD digits {hour10,hour1,min10,min1,sec10,sec1}, 4 bits each.
REQ-011 SHALL have port field_sel  output  3  one-hot field being edited {hour,min,sec}; 0 outside SET.
REQ-012 SHALL have ports norm, alarm, running  output  1 each  not-in-SET, alarm active, state==RUN.

Function
REQ-013 SHALL detect each button's rising edge as level & ~previous-registered-level; all actions below use edges only.
REQ-014 SHALL implement states IDLE, SET, RUN, ALARM; bcd SHALL reflect current hour/min/sec registered, one-cycle latency.
REQ-015 SHALL give esc edge highest priority: any state -> IDLE, hour/min/sec/preset/prescaler = 0.
REQ-016 SHALL, when mode=0, hold IDLE with all counters and preset 0, ignoring buttons.
REQ-017 IDLE: enter edge -> SET, field=sec; right edge -> RUN if dir=1 or time!=0; right edge with dir=0 and time=0 -> stay IDLE.
REQ-018 SET: left edge rotates field sec->min->hour->sec; right edge rotates sec->hour->min->sec.
REQ-019 SET: up edge increments field, down edge decrements; sec/min wrap 59<->0, hour wraps HOUR_MAX<->0.
REQ-020 SET: enter edge -> IDLE and copies hour/min/sec into preset; enter outranks left/right/up/down in the same cycle.
REQ-021 RUN: prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 it returns to 0 and issues one tick.
REQ-022 RUN, dir=0: tick decrements time with sec/min borrow; tick that yields 00:00:00 -> ALARM same edge.
REQ-023 RUN, dir=1: tick increments with carry; at HOUR_MAX:59:59 time saturates and state -> IDLE.
REQ-024 RUN: enter edge -> IDLE (pause), time retained, prescaler cleared; enter outranks a coincident tick.
REQ-025 ALARM: alarm=1; ALARM_SECS ticks or any of up/down/left/right/enter edge ends alarm.
REQ-026 Alarm end with RELOAD=1 and preset!=0: load preset, prescaler 0, -> RUN; otherwise -> IDLE with time 0.
REQ-027 dir SHALL be latched at IDLE->RUN; changes during RUN SHALL be ignored.
REQ-028 norm SHALL be 0 exactly while in SET; running SHALL be 1 exactly in RUN; outputs registered, glitch-free.
REQ-029 Counter widths SHALL be sized by $clog2 of their ranges; no overflow beyond stated wraps.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, hour/min/sec/preset/prescaler/edge registers 0, field_sel=0, alarm=0, running=0, norm=1, bcd=0.
REQ-031 A button held through rst deassertion SHALL NOT produce an edge until released and pressed again.
REQ-032 rst asserted mid-RUN or mid-ALARM SHALL abort with no residual alarm or tick.

Verification (TICK_DIV=4, ALARM_SECS=2)
REQ-033 enter, up x3, left, up x1, enter -> field_sel 001,010; bcd=0x000103; norm 0 then 1.
REQ-034 preset 00:00:02, dir=0, right -> ticks every 4 cycles, 01 then 00, alarm=1 for 8 cycles, then IDLE, bcd 0.
REQ-035 Same with RELOAD=1 -> after alarm bcd=0x000002, running=1, countdown repeats.
REQ-036 In SET min=0 down -> 59; hour=0 down -> HOUR_MAX; sec=59 up -> 0.
REQ-037 dir=1 run from HOUR_MAX:59:58 -> :59 then IDLE, no wrap; esc mid-RUN -> bcd 0, IDLE next cycle.
REQ-038 rst pulse mid-ALARM -> alarm 0 asynchronously; held enter after reset produces no SET entry.
